// File: rtl/db_hit_detector.sv
// Drum hit detector fed by strobed dB attenuation samples (0 = full scale).
// Trigger on threshold crossing, track loudest sample over the attack window, then hold off and re-arm with hysteresis.
module db_hit_detector #(
  parameter int ATTACK_SAMPLES  = 4,
  parameter int HOLDOFF_SAMPLES = 64,
  parameter int HYST_DB         = 6,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       db_valid,
  input  logic [8:0] db_in,
  input  logic [8:0] thresh_db,
  output logic       hit,
  output logic [8:0] hit_peak_db,
  output logic [3:0] hit_velocity,
  output logic       armed
);

  typedef enum logic [1:0] {QUIET, ATTACK, HOLDOFF, REARM} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       peak_q, peak_d;
  logic [8:0]       thr_q, thr_d;
  logic             hit_q, hit_d;
  logic [8:0]       hit_peak_q, hit_peak_d;
  logic [3:0]       hit_vel_q, hit_vel_d;
  logic             armed_q, armed_d;

  logic [8:0]       d;
  logic [CNT_W-1:0] cnt_inc;
  logic             issue;
  logic [8:0]       issue_peak;
  logic [8:0]       issue_thr;
  logic [8:0]       vel_diff;

  // Negative converter output means louder than full scale; treat as 0 dB.
  assign d       = db_in[8] ? 9'd0 : db_in;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= QUIET;
      cnt_q      <= '0;
      peak_q     <= '0;
      thr_q      <= '0;
      hit_q      <= 1'b0;
      hit_peak_q <= '0;
      hit_vel_q  <= '0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      thr_q      <= thr_d;
      hit_q      <= hit_d;
      hit_peak_q <= hit_peak_d;
      hit_vel_q  <= hit_vel_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    thr_d      = thr_q;
    issue      = 1'b0;
    issue_peak = peak_q;
    issue_thr  = thr_q;
    if (db_valid) begin
      case (state_q)
        QUIET: begin
          if (d < thresh_db) begin
            thr_d  = thresh_db;
            peak_d = d;
            if (ATTACK_SAMPLES == 1) begin
              issue      = 1'b1;
              issue_peak = d;
              issue_thr  = thresh_db;
              cnt_d      = '0;
              state_d    = HOLDOFF;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ATTACK;
            end
          end
        end
        ATTACK: begin
          peak_d     = (d < peak_q) ? d : peak_q;
          issue_peak = peak_d;
          if (cnt_inc == CNT_W'(ATTACK_SAMPLES)) begin
            issue   = 1'b1;
            cnt_d   = '0;
            state_d = HOLDOFF;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HOLDOFF: begin
          if (cnt_inc == CNT_W'(HOLDOFF_SAMPLES)) begin
            cnt_d   = '0;
            state_d = REARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        REARM: begin
          // Widened compare so a threshold near the top cannot wrap into an early re-arm.
          if ({1'b0, d} >= ({1'b0, thr_q} + 10'(HYST_DB))) state_d = QUIET;
        end
        default: state_d = QUIET;
      endcase
    end
  end

  assign vel_diff = issue_thr - issue_peak;

  always_comb begin
    hit_d      = issue;
    hit_peak_d = hit_peak_q;
    hit_vel_d  = hit_vel_q;
    if (issue) begin
      hit_peak_d = issue_peak;
      hit_vel_d  = (vel_diff > 9'd15) ? 4'hF : vel_diff[3:0];
    end
    armed_d = (state_d == QUIET);
  end

  assign hit          = hit_q;
  assign hit_peak_db  = hit_peak_q;
  assign hit_velocity = hit_vel_q;
  assign armed        = armed_q;

endmodule

// File: tb/tb_db_hit_detector.sv
// Directed bench for db_hit_detector: episode-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_db_hit_detector;
  localparam int A = 4, H = 8, HY = 6, CW = 8;

  logic       clock = 0;
  logic       reset = 1;
  logic       db_valid = 0;
  logic [8:0] db_in = 0;
  logic [8:0] thresh_db = 9'd20;
  logic       hit;
  logic [8:0] hit_peak_db;
  logic [3:0] hit_velocity;
  logic       armed;

  db_hit_detector #(.ATTACK_SAMPLES(A), .HOLDOFF_SAMPLES(H), .HYST_DB(HY), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .db_valid(db_valid), .db_in(db_in), .thresh_db(thresh_db),
    .hit(hit), .hit_peak_db(hit_peak_db), .hit_velocity(hit_velocity), .armed(armed)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: an "episode" starts at a trigger sample; k counts valid samples since (trigger = 1).
  // k in 1..A is attack, A+1..A+H is hold-off, beyond that the sample is tested for re-arm.
  bit m_active;
  int m_k, m_thr, m_peak;
  bit e_hit, e_armed;
  int e_peak, e_vel;

  always @(posedge clock) begin
    int dv, diff;
    if (reset) begin
      m_active = 0; m_k = 0; e_hit = 0; e_peak = 0; e_vel = 0; e_armed = 1;
    end else begin
      e_hit = 0;
      if (db_valid) begin
        dv = db_in[8] ? 0 : int'(db_in);
        if (!m_active) begin
          if (dv < int'(thresh_db)) begin
            m_active = 1; m_k = 1; m_thr = int'(thresh_db); m_peak = dv;
          end
        end else begin
          m_k++;
          if (m_k <= A) begin
            if (dv < m_peak) m_peak = dv;
          end else if (m_k > A + H) begin
            if (dv >= m_thr + HY) m_active = 0;
          end
        end
        if (m_active && m_k == A && (m_k == 1 || dv >= 0)) begin
          if (m_k == A) begin
            e_hit = 1; e_peak = m_peak;
            diff = m_thr - m_peak;
            e_vel = (diff > 15) ? 15 : diff;
          end
        end
      end
      e_armed = !m_active;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("hit", int'(hit), int'(e_hit));
      chk("hit_peak_db", int'(hit_peak_db), e_peak);
      chk("hit_velocity", int'(hit_velocity), e_vel);
      chk("armed", int'(armed), int'(e_armed));
    end
  end

  task automatic sample(input logic [8:0] v);
    @(negedge clock);
    db_valid = 1; db_in = v;
    @(negedge clock);
    db_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic lit(input string tag, input int h, input int p, input int v, input int a);
    chk({tag, "_hit"}, int'(hit), h);
    chk({tag, "_peak"}, int'(hit_peak_db), p);
    chk({tag, "_vel"}, int'(hit_velocity), v);
    chk({tag, "_armed"}, int'(armed), a);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 0;
    chk_en = 1;
    lit("reset", 0, 0, 0, 1);

    // 1: basic attack window
    sample(9'd40); sample(9'd40); sample(9'd12);
    lit("t1_attack", 0, 0, 0, 0);
    sample(9'd8); sample(9'd15); sample(9'd30);
    lit("t1_hit", 1, 8, 12, 0);
    @(negedge clock);
    chk("t1_pulse_one_cycle", int'(hit), 0);

    // 2: hold-off and hysteresis re-arm
    repeat (H) sample(9'd5);
    repeat (3) sample(9'd5);
    lit("t2_rearm_wait", 0, 8, 12, 0);
    sample(9'd25);
    chk("t2_25_not_armed", int'(armed), 0);
    sample(9'd26);
    chk("t2_26_armed", int'(armed), 1);
    sample(9'd10); sample(9'd10); sample(9'd10); sample(9'd10);
    lit("t2_hit", 1, 10, 10, 0);

    // 3: long gap mid-attack, threshold change outside QUIET ignored
    do_reset();
    sample(9'd12); sample(9'd8);
    thresh_db = 9'd200;
    repeat (100) @(negedge clock);
    lit("t3_gap", 0, 0, 0, 0);
    sample(9'd15); sample(9'd30);
    lit("t3_hit", 1, 8, 12, 0);
    thresh_db = 9'd20;

    // 4: reset aborts a window
    do_reset();
    sample(9'd12);
    do_reset();
    lit("t4_after_reset", 0, 0, 0, 1);
    repeat (6) @(negedge clock);
    lit("t4_no_hit", 0, 0, 0, 1);
    sample(9'd40); sample(9'd9); sample(9'd9); sample(9'd9); sample(9'd9);
    lit("t4_hit", 1, 9, 11, 0);

    // 5: equal-to-threshold and zero threshold never trigger
    do_reset();
    repeat (10) sample(9'd20);
    lit("t5_eq", 0, 0, 0, 1);
    thresh_db = 9'd0;
    repeat (6) sample(9'd0);
    lit("t5_zero", 0, 0, 0, 1);

    // 6: clamped negative input and velocity saturation
    thresh_db = 9'd40;
    sample(9'h1FD); sample(9'd50); sample(9'd50); sample(9'd50);
    lit("t6_hit", 1, 0, 15, 0);

    repeat (3) @(negedge clock);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
